// File: rtl/mandelbrot_view_controller.sv
// Mandelbrot view controller: key auto-repeat into pending pan/zoom
// registers, committed to the renderer one frame at a time.
module mandelbrot_view_controller #(
    parameter int unsigned REPEAT_TICKS = 5000000,
    parameter int unsigned SCALE_MAX    = 24,
    parameter logic [31:0] PAN_BASE     = 32'h0100_0000,
    parameter logic [31:0] LIMIT        = 32'h2000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        zoom_in,
    input  logic        zoom_out,
    input  logic        pan_up,
    input  logic        pan_down,
    input  logic        pan_left,
    input  logic        pan_right,
    input  logic        render_done,
    output logic        render_start,
    output logic        render_busy,
    output logic [31:0] center_re,
    output logic [31:0] center_im,
    output logic [4:0]  scale,
    output logic [15:0] frame_count
);

    localparam int CW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [4:0] SMAX = 5'(SCALE_MAX);
    localparam logic signed [32:0] HI = $signed({1'b0, LIMIT});
    localparam logic signed [32:0] LO = -HI;
    localparam logic [31:0] RESET_RE = 32'hF800_0000;

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [31:0] p_re, p_im, delta, nx_re, nx_im;
    logic [4:0]  p_scale, nx_scale;
    logic        dirty, any_key, action, changed;

    // Signed 33-bit step with symmetric clamp; opposing keys cancel.
    function automatic logic [31:0] step(
        input logic [31:0] v,
        input logic [31:0] d,
        input logic        inc,
        input logic        dec
    );
        logic signed [32:0] s;
        s = $signed({v[31], v});
        if (inc && !dec)
            s = s + $signed({1'b0, d});
        else if (dec && !inc)
            s = s - $signed({1'b0, d});
        if (s > HI)
            s = HI;
        else if (s < LO)
            s = LO;
        return s[31:0];
    endfunction

    assign any_key = zoom_in | zoom_out | pan_up | pan_down | pan_left | pan_right;
    assign action  = any_key && (cnt == '0);
    assign delta   = PAN_BASE >> p_scale;
    assign nx_re   = step(p_re, delta, pan_right, pan_left);
    assign nx_im   = step(p_im, delta, pan_up, pan_down);

    always_comb begin
        nx_scale = p_scale;
        if (zoom_in && !zoom_out && p_scale != SMAX)
            nx_scale = p_scale + 5'd1;
        else if (zoom_out && !zoom_in && p_scale != 5'd0)
            nx_scale = p_scale - 5'd1;
    end

    assign changed = action &&
        (nx_re != p_re || nx_im != p_im || nx_scale != p_scale);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!any_key || cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_re    <= RESET_RE;
            p_im    <= '0;
            p_scale <= '0;
        end else if (changed) begin
            p_re    <= nx_re;
            p_im    <= nx_im;
            p_scale <= nx_scale;
        end
    end

    // A change in the START cycle keeps dirty set so it gets its own frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            dirty <= 1'b1;
        else if (changed)
            dirty <= 1'b1;
        else if (state == START)
            dirty <= 1'b0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dirty) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (render_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            render_start <= 1'b0;
            center_re    <= RESET_RE;
            center_im    <= '0;
            scale        <= '0;
            frame_count  <= '0;
        end else begin
            state        <= state_next;
            render_start <= (state_next == START);
            if (state == START) begin
                center_re <= p_re;
                center_im <= p_im;
                scale     <= p_scale;
            end
            if (state == BUSY && render_done)
                frame_count <= frame_count + 16'd1;
        end
    end

    assign render_busy = (state != IDLE);

endmodule

// File: tb/tb_mandelbrot_view_controller.sv
// Scoreboard bench for mandelbrot_view_controller: expected committed
// views are queued before each frame and checked when the frame starts.
module tb_mandelbrot_view_controller;

    localparam int RT = 4;
    localparam logic [5:0] K_ZIN  = 6'b100000;
    localparam logic [5:0] K_ZOUT = 6'b010000;
    localparam logic [5:0] K_UP   = 6'b001000;
    localparam logic [5:0] K_DOWN = 6'b000100;
    localparam logic [5:0] K_RT   = 6'b000001;

    typedef logic [68:0] view_t;

    logic        clock;
    logic        reset_n;
    logic [5:0]  keys;
    logic        render_done;
    logic        render_start;
    logic        render_busy;
    logic [31:0] center_re;
    logic [31:0] center_im;
    logic [4:0]  scale;
    logic [15:0] frame_count;

    int    checks = 0;
    int    failures = 0;
    int    start_cnt = 0;
    int    lat;
    view_t exp_q[$];

    mandelbrot_view_controller #(.REPEAT_TICKS(RT)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .zoom_in(keys[5]),
        .zoom_out(keys[4]),
        .pan_up(keys[3]),
        .pan_down(keys[2]),
        .pan_left(keys[1]),
        .pan_right(keys[0]),
        .render_done(render_done),
        .render_start(render_start),
        .render_busy(render_busy),
        .center_re(center_re),
        .center_im(center_im),
        .scale(scale),
        .frame_count(frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic view_t vw(input logic [31:0] re,
                                 input logic [31:0] im,
                                 input logic [4:0] sc);
        return {re, im, sc};
    endfunction

    // Frame-start monitor: the committed view is valid once START has ended.
    always begin
        view_t e;
        @(posedge clock);
        #1;
        if (reset_n && render_start) begin
            start_cnt++;
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_re", center_re, e[68:37]);
                chk("commit_im", center_im, e[36:5]);
                chk("commit_scale", 32'(scale), 32'(e[4:0]));
            end
        end
    end

    task automatic press(input logic [5:0] k, input int n);
        @(negedge clock);
        keys = k;
        repeat ((n - 1) * RT + 1) @(negedge clock);
        keys = '0;
        @(negedge clock);
    endtask

    task automatic wait_starts(input int n, input int budget, output int l);
        l = 0;
        while (start_cnt < n && l < budget) begin
            @(posedge clock);
            #2;
            l++;
        end
        chk("start_timeout", 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic done_pulse();
        repeat (2) @(negedge clock);
        render_done = 1'b1;
        @(negedge clock);
        render_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        keys = '0;
        render_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_start", 32'(render_start), 32'd0);
        chk("rst_busy", 32'(render_busy), 32'd0);
        chk("rst_frames", 32'(frame_count), 32'd0);
        chk("rst_re", center_re, 32'hF800_0000);
        chk("rst_scale", 32'(scale), 32'd0);

        // First frame after reset with the default view.
        exp_q.push_back(vw(32'hF800_0000, 32'h0, 5'd0));
        reset_n = 1'b1;
        wait_starts(1, 4, lat);
        chk("rst_latency", 32'(lat <= 2), 32'd1);
        repeat (5) @(negedge clock);
        chk("hold_busy", 32'(render_busy), 32'd1);
        chk("no_restart", start_cnt, 32'd1);
        done_pulse();
        chk("frames_1", 32'(frame_count), 32'd1);
        repeat (8) @(negedge clock);
        chk("idle_nostart", start_cnt, 32'd1);
        chk("idle_busy", 32'(render_busy), 32'd0);

        // Three repeat actions of pan_right over nine held cycles.
        exp_q.push_back(vw(32'hF900_0000, 32'h0, 5'd0));
        exp_q.push_back(vw(32'hFB00_0000, 32'h0, 5'd0));
        press(K_RT, 3);
        wait_starts(2, 10, lat);
        chk("busy_re", center_re, 32'hF900_0000);
        chk("one_start", start_cnt, 32'd2);
        done_pulse();
        wait_starts(3, 10, lat);
        done_pulse();
        chk("frames_3", 32'(frame_count), 32'd3);

        // Opposing pans cancel, zoom still applies.
        exp_q.push_back(vw(32'hFB00_0000, 32'h0, 5'd1));
        press(K_UP | K_DOWN | K_ZIN, 1);
        wait_starts(4, 10, lat);

        // While busy, walk p_im to 1FF00000 then push past the clamp.
        press(K_ZOUT, 1);
        press(K_UP, 31);
        press(K_ZIN, 4);
        press(K_UP, 15);
        press(K_ZOUT, 4);
        press(K_UP, 1);
        chk("busy_hold_im", center_im, 32'h0);
        chk("busy_hold_sc", 32'(scale), 32'd1);
        chk("busy_nostart", start_cnt, 32'd4);
        exp_q.push_back(vw(32'hFB00_0000, 32'h2000_0000, 5'd0));
        done_pulse();
        wait_starts(5, 10, lat);
        done_pulse();
        chk("frames_5", 32'(frame_count), 32'd5);
        press(K_UP, 1);
        repeat (10) @(negedge clock);
        chk("clamp_noframe", start_cnt, 32'd5);

        // Zoom saturation at the top level.
        exp_q.push_back(vw(32'hFB00_0000, 32'h2000_0000, 5'd1));
        exp_q.push_back(vw(32'hFB00_0000, 32'h2000_0000, 5'd24));
        press(K_ZIN, 30);
        wait_starts(6, 10, lat);
        done_pulse();
        wait_starts(7, 10, lat);
        done_pulse();
        chk("frames_7", 32'(frame_count), 32'd7);
        press(K_ZIN, 2);
        repeat (10) @(negedge clock);
        chk("sat_noframe", start_cnt, 32'd7);

        // Smallest pan step at scale 24, then reset mid-frame.
        exp_q.push_back(vw(32'hFB00_0001, 32'h2000_0000, 5'd24));
        press(K_RT, 1);
        wait_starts(8, 10, lat);
        repeat (3) @(negedge clock);
        chk("pre_rst_busy", 32'(render_busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_busy", 32'(render_busy), 32'd0);
        chk("mid_rst_frames", 32'(frame_count), 32'd0);
        chk("mid_rst_re", center_re, 32'hF800_0000);
        chk("mid_rst_im", center_im, 32'h0);
        exp_q.push_back(vw(32'hF800_0000, 32'h0, 5'd0));
        reset_n = 1'b1;
        wait_starts(9, 4, lat);
        chk("mid_rst_latency", 32'(lat <= 2), 32'd1);
        done_pulse();
        chk("frames_after_rst", 32'(frame_count), 32'd1);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mandelbrot_view_controller.md
MANDELBROT_VIEW_CONTROLLER -- requirements
Module: mandelbrot_view_controller

Interface
REQ-001 Parameter REPEAT_TICKS, default 5000000, clock cycles between auto-repeat actions while a key is held (10 Hz at 50 MHz).
REQ-002 Parameter SCALE_MAX, default 24, maximum zoom level.
REQ-003 Parameter PAN_BASE, default 32'h0100_0000, pan step at scale 0, as Q4.28 (1/16).
REQ-004 Parameter LIMIT, default 32'h2000_0000, coordinate magnitude clamp, as Q4.28 (2.0).
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 zoom_in, zoom_out, pan_up, pan_down, pan_left, pan_right  in  1 each  held-key levels, synchronous to clock.
REQ-008 render_done  in  1  one-cycle pulse from renderer, frame complete.
REQ-009 render_start  out  1  one-cycle pulse, committed view valid, begin frame.
REQ-010 render_busy  out  1  high in START and BUSY states.
REQ-011 center_re, center_im  out  32  committed view centre, signed Q4.28.
REQ-012 scale  out  5  committed zoom level; pixel step = base step >> scale.
REQ-013 frame_count  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-014 Pending registers p_re, p_im, p_scale and a dirty flag are maintained separately from the committed outputs.
REQ-015 any_key = OR of the six key inputs.
REQ-016 Repeat counter: forced to 0 while any_key=0; while any_key=1 it increments and wraps from REPEAT_TICKS-1 to 0.
REQ-017 Action fires in every cycle with any_key=1 and counter=0: first action on the first held cycle, then every REPEAT_TICKS cycles.
REQ-018 Zoom on action: zoom_in only -> p_scale+1, saturating at SCALE_MAX; zoom_out only -> p_scale-1, saturating at 0; both or neither -> unchanged.
REQ-019 Pan delta = PAN_BASE >> p_scale, using p_scale before this action's zoom update.
REQ-020 pan_up only -> p_im+delta; pan_down only -> p_im-delta; both or neither -> p_im unchanged. pan_right/pan_left apply identically to p_re.
REQ-021 Pan sums use 33-bit signed arithmetic and are clamped to [-LIMIT, +LIMIT].
REQ-022 dirty is set on any action that changes p_re, p_im or p_scale; a saturated no-op action leaves dirty unchanged.
REQ-023 FSM states IDLE, START, BUSY.
REQ-024 IDLE: dirty=1 -> START, else stay; render_done ignored.
REQ-025 START (exactly one cycle): render_start=1; center_re/center_im/scale <= p_re/p_im/p_scale; dirty cleared; -> BUSY.
REQ-026 If an action changes pending values in the START cycle, dirty ends set (the action wins) and the committed outputs take the pre-action pending values.
REQ-027 BUSY: render_done=1 -> IDLE and frame_count+1; render_done is sampled only in BUSY.
REQ-028 Committed outputs are stable from START until the next START.
REQ-029 Key actions update the pending registers in any state.
REQ-030 render_start is a registered output: high only in the cycle the FSM is in START.

Reset
REQ-031 reset_n=0 -> FSM IDLE, dirty=1, counter=0, render_start=0, frame_count=0.
REQ-032 reset_n=0 -> p_re=center_re=32'hF800_0000 (-0.5), p_im=center_im=0, p_scale=scale=0.
REQ-033 Reset asserted mid-frame abandons the frame; the first render_start follows release within 2 cycles.

Verification
REQ-034 Release reset, no keys -> render_start pulse at cycle 1-2 with center_re=F8000000, im=0, scale=0; hold BUSY; render_done -> frame_count=1, no further start.
REQ-035 REPEAT_TICKS=4, hold pan_right for 9 cycles after IDLE -> 3 actions, p_re=F8000000+3*01000000=FB000000; next committed center_re=FB000000.
REQ-036 Hold zoom_in for 30 actions -> p_scale saturates at 24; after saturation, dirty stays clear and no extra render_start occurs.
REQ-037 p_im=1FF00000, scale 0, pan_up action -> p_im=20000000 (clamped); repeat -> p_im unchanged, no new frame.
REQ-038 Action during BUSY -> outputs unchanged until render_done; exactly one render_start then follows, carrying the latest pending values.
REQ-039 Press pan_up+pan_down+zoom_in together -> only p_scale changes (+1); p_im unchanged.
